// File: rtl/clock_manager_pkg.sv
// Shared types and level constants for the clock manager.
package clock_manager_pkg;

    typedef enum logic [1:0] {
        CM_OFF       = 2'd0,
        CM_STABILIZE = 2'd1,
        CM_RUN       = 2'd2
    } cm_state_t;

    localparam logic ActiveLow  = 1'b0;
    localparam logic ActiveHigh = 1'b1;

endpackage

// File: rtl/clock_manager_power_sync.sv
// Two-flop level synchroniser with a parametric reset value.
module power_sync
    import clock_manager_pkg::*;
#(
    parameter logic RESET_VAL = ActiveHigh
) (
    input  logic clock,
    input  logic reset,
    input  logic din,
    output logic dout
);

    logic meta;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VAL;
            dout <= RESET_VAL;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/clock_manager.sv
// Power-on reset stretcher with a runtime-loadable clock-enable divider.
module clock_manager
    import clock_manager_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 16,
    parameter int unsigned DIV_W         = 8,
    parameter int unsigned DEFAULT_DIV   = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             power,
    input  logic             div_load,
    input  logic [DIV_W-1:0] div_value,
    output logic             div_ack,
    output logic             sys_reset,
    output logic             ready,
    output logic             tick,
    output logic [1:0]       state
);

    localparam int unsigned STAB_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam logic [STAB_W-1:0] STAB_INIT = STAB_W'(STABLE_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_RST   = DIV_W'(DEFAULT_DIV);

    cm_state_t          state_q, state_d;
    logic [STAB_W-1:0]  stab_q, stab_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [DIV_W-1:0]   ratio_q, ratio_d;
    logic               tick_q, tick_d;
    logic               ack_q, ack_d;
    logic               sysrst_q, sysrst_d;
    logic               ready_q, ready_d;
    logic               pwr_s;
    logic               load_ok;

    power_sync #(.RESET_VAL(ActiveHigh)) u_power_sync (
        .clock (clock),
        .reset (reset),
        .din   (power),
        .dout  (pwr_s)
    );

    assign load_ok = div_load && !ack_q;

    // Next-state, divider and handshake; a load overrides the divider wrap.
    always_comb begin
        state_d   = state_q;
        stab_d    = stab_q;
        div_cnt_d = div_cnt_q;
        ratio_d   = ratio_q;
        tick_d    = 1'b0;
        ack_d     = 1'b0;
        sysrst_d  = ActiveLow;
        ready_d   = 1'b0;

        case (state_q)
            CM_OFF: begin
                div_cnt_d = '0;
                if (pwr_s == ActiveLow) begin
                    state_d = CM_STABILIZE;
                    stab_d  = STAB_INIT;
                end
            end
            CM_STABILIZE: begin
                div_cnt_d = '0;
                if (pwr_s != ActiveLow) begin
                    state_d = CM_OFF;
                end else if (stab_q == '0) begin
                    state_d  = CM_RUN;
                    sysrst_d = ActiveHigh;
                    ready_d  = 1'b1;
                end else begin
                    stab_d = stab_q - STAB_W'(1);
                end
            end
            CM_RUN: begin
                if (pwr_s != ActiveLow) begin
                    state_d   = CM_OFF;
                    div_cnt_d = '0;
                end else begin
                    sysrst_d = ActiveHigh;
                    ready_d  = 1'b1;
                    if (div_cnt_q == ratio_q - DIV_W'(1)) begin
                        div_cnt_d = '0;
                        tick_d    = 1'b1;
                    end else begin
                        div_cnt_d = div_cnt_q + DIV_W'(1);
                    end
                end
            end
            default: begin
                state_d   = CM_OFF;
                div_cnt_d = '0;
            end
        endcase

        if (load_ok) begin
            ratio_d   = (div_value == '0) ? DIV_W'(1) : div_value;
            div_cnt_d = '0;
            tick_d    = 1'b0;
            ack_d     = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= CM_OFF;
            stab_q    <= '0;
            div_cnt_q <= '0;
            ratio_q   <= DIV_RST;
            tick_q    <= 1'b0;
            ack_q     <= 1'b0;
            sysrst_q  <= ActiveLow;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            stab_q    <= stab_d;
            div_cnt_q <= div_cnt_d;
            ratio_q   <= ratio_d;
            tick_q    <= tick_d;
            ack_q     <= ack_d;
            sysrst_q  <= sysrst_d;
            ready_q   <= ready_d;
        end
    end

    assign state     = state_q;
    assign div_ack   = ack_q;
    assign sys_reset = sysrst_q;
    assign ready     = ready_q;
    assign tick      = tick_q;

endmodule
